prog_instr_mem: RTL and testbench

- Parametrised instruction memory with a streaming program loader, for the IF stage.
- Replaces the fixed-program memory, whose program is hardcoded one word per cycle.
- Any program image is loaded through a valid/ready word stream, after which the memory serves byte-addressed fetches from the PC.
- Adds load-length tracking, overflow detection, misaligned/out-of-range fetch faults, a fetch enable, and reload without a full reset.

---
 rtl/prog_instr_mem.sv | 102 ++++++++++
 tb/tb_prog_instr_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_instr_mem.sv
// prog_instr_mem: instruction memory loaded by a valid/ready word stream.
// Serves byte-addressed fetches with a 1-cycle latency once a program is loaded.
module prog_instr_mem #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    IDX_W      = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  program_loaded,
    output logic                  load_overflow,
    output logic [IDX_W:0]        load_count,
    input  logic [31:0]           fromPC,
    input  logic                  fetch_en,
    output logic [DATA_WIDTH-1:0] fullInstruction,
    output logic                  instr_valid,
    output logic                  addr_fault
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]        count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept, fetch, bad;
    logic [IDX_W-1:0]      idx;

    assign load_ready      = state_q == LOAD;
    assign program_loaded  = state_q == DONE;
    assign load_overflow   = overflow_q;
    assign load_count      = count_q;
    assign fullInstruction = instr_q;
    assign instr_valid     = valid_q;
    assign addr_fault      = fault_q;

    // a start_load in the same cycle wins over any stream word
    assign accept = load_ready && load_valid && !start_load;
    assign fetch  = program_loaded && fetch_en;
    assign idx    = fromPC[IDX_W+1:2];
    assign bad    = (fromPC[1:0] != 2'b00) || ((fromPC >> (IDX_W + 2)) != 32'd0)
                    || ({1'b0, idx} >= count_q);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (start_load) begin
            state_d    = LOAD;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            count_d  = count_q + (IDX_W+1)'(1);
            if (load_last) begin
                state_d = DONE;
            end else if (wr_ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d    = DONE;
                overflow_d = 1'b1;
            end
        end
        instr_d = fetch ? (bad ? NOP_WORD : mem[idx]) : instr_q;
        fault_d = fetch ? bad : fault_q;
        valid_d = fetch;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    // writes happen only while not loaded, so reads never collide with them
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr_q] <= load_data;
    end
endmodule

// File: tb/tb_prog_instr_mem.sv
// tb_prog_instr_mem: directed checks of loading, fetching, faults and reloads.
// A second DEPTH=8 instance exercises the overflow path.
module tb_prog_instr_mem;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_load = 0, load_valid = 0, load_last = 0, fetch_en = 0;
    logic [31:0] load_data = '0, fromPC = '0;
    logic        load_ready, program_loaded, load_overflow, instr_valid, addr_fault;
    logic [8:0]  load_count;
    logic [31:0] fullInstruction;

    logic        s_start = 0, s_valid = 0, s_last = 0, s_en = 0;
    logic [31:0] s_data = '0, s_pc = '0;
    logic        s_ready, s_loaded, s_overflow, s_ivalid, s_fault;
    logic [3:0]  s_count;
    logic [31:0] s_instr;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } vec_t;
    vec_t vecs[$];

    prog_instr_mem u_dut (
        .clock(clock), .reset(reset), .start_load(start_load), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .program_loaded(program_loaded), .load_overflow(load_overflow), .load_count(load_count),
        .fromPC(fromPC), .fetch_en(fetch_en), .fullInstruction(fullInstruction),
        .instr_valid(instr_valid), .addr_fault(addr_fault)
    );

    prog_instr_mem #(.DEPTH(8)) u_small (
        .clock(clock), .reset(reset), .start_load(s_start), .load_valid(s_valid),
        .load_data(s_data), .load_last(s_last), .load_ready(s_ready),
        .program_loaded(s_loaded), .load_overflow(s_overflow), .load_count(s_count),
        .fromPC(s_pc), .fetch_en(s_en), .fullInstruction(s_instr),
        .instr_valid(s_ivalid), .addr_fault(s_fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_main(input int n, input logic [31:0] base);
        start_load = 1;
        tick();
        start_load = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1;
            load_data  = base + 32'(i);
            load_last  = (i == n - 1);
            chk("load_ready_during_load", load_ready, 1);
            tick();
        end
        load_valid = 0;
        load_last  = 0;
    endtask

    initial begin
        #2 reset = 0;
        #2;
        chk("rst_ready", load_ready, 0);
        chk("rst_loaded", program_loaded, 0);
        chk("rst_overflow", load_overflow, 0);
        chk("rst_count", load_count, 0);
        chk("rst_instr", fullInstruction, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", addr_fault, 0);
        tick();
        tick();
        reset = 1;
        tick();
        chk("idle_loaded", program_loaded, 0);

        load_main(46, 32'h2000_0000);
        chk("load46_loaded", program_loaded, 1);
        chk("load46_count", load_count, 46);
        chk("load46_overflow", load_overflow, 0);
        chk("load46_ready_off", load_ready, 0);

        for (int i = 0; i < 46; i++)
            vecs.push_back('{32'(i * 4), 1'b1, 32'h2000_0000 + 32'(i), 1'b1, 1'b0});
        vecs.push_back('{32'd2, 1'b1, 32'd0, 1'b1, 1'b1});
        vecs.push_back('{32'd184, 1'b1, 32'd0, 1'b1, 1'b1});
        vecs.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b1});
        vecs.push_back('{32'd4, 1'b1, 32'h2000_0001, 1'b1, 1'b0});
        vecs.push_back('{32'h0001_0000, 1'b1, 32'd0, 1'b1, 1'b1});
        vecs.push_back('{32'd180, 1'b1, 32'h2000_002d, 1'b1, 1'b0});
        foreach (vecs[k]) begin
            fromPC   = vecs[k].pc;
            fetch_en = vecs[k].en;
            tick();
            chk($sformatf("fetch%0d_instr", k), fullInstruction, vecs[k].instr);
            chk($sformatf("fetch%0d_valid", k), instr_valid, vecs[k].valid);
            chk($sformatf("fetch%0d_fault", k), addr_fault, vecs[k].fault);
        end
        fetch_en = 0;

        begin
            int acc = 0;
            s_start = 1;
            tick();
            s_start = 0;
            for (int i = 0; i < 10; i++) begin
                s_valid = 1;
                s_data  = 32'h30 + 32'(i);
                if (s_ready) acc++;
                tick();
            end
            s_valid = 0;
            chk("ovf_accepted", acc, 8);
        end
        chk("ovf_flag", s_overflow, 1);
        chk("ovf_count", s_count, 8);
        chk("ovf_loaded", s_loaded, 1);
        chk("ovf_ready_off", s_ready, 0);
        s_pc = 28;
        s_en = 1;
        tick();
        chk("small_last_instr", s_instr, 32'h37);
        chk("small_last_fault", s_fault, 0);
        s_pc = 32;
        tick();
        chk("small_oob_fault", s_fault, 1);
        chk("small_oob_instr", s_instr, 0);
        s_en = 0;

        start_load = 1;
        tick();
        start_load = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1;
            load_data  = 32'h55 + 32'(i);
            tick();
        end
        load_valid = 0;
        reset = 0;
        #1;
        chk("midrst_ready", load_ready, 0);
        chk("midrst_loaded", program_loaded, 0);
        chk("midrst_overflow", load_overflow, 0);
        chk("midrst_count", load_count, 0);
        chk("midrst_instr", fullInstruction, 0);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_fault", addr_fault, 0);
        reset = 1;
        tick();
        chk("post_rst_idle_ready", load_ready, 0);
        load_main(2, 32'hA0);
        chk("reload2_count", load_count, 2);
        chk("reload2_loaded", program_loaded, 1);
        fromPC   = 8;
        fetch_en = 1;
        tick();
        chk("reload2_pc8_fault", addr_fault, 1);
        chk("reload2_pc8_instr", fullInstruction, 0);
        chk("reload2_pc8_valid", instr_valid, 1);
        fromPC = 4;
        tick();
        chk("reload2_pc4_instr", fullInstruction, 32'hA1);
        chk("reload2_pc4_fault", addr_fault, 0);

        fromPC     = 0;
        start_load = 1;
        tick();
        start_load = 0;
        chk("restart_loaded", program_loaded, 0);
        chk("restart_ready", load_ready, 1);
        chk("restart_count", load_count, 0);
        chk("restart_fetch_valid", instr_valid, 1);
        chk("restart_fetch_instr", fullInstruction, 32'hA0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_valid", instr_valid, 0);
            chk("wait_ready", load_ready, 1);
        end
        load_valid = 1;
        load_data  = 32'hB0;
        load_last  = 1;
        tick();
        load_valid = 0;
        load_last  = 0;
        chk("reload1_valid", instr_valid, 0);
        chk("reload1_loaded", program_loaded, 1);
        chk("reload1_count", load_count, 1);
        tick();
        chk("reload1_fetch_valid", instr_valid, 1);
        chk("reload1_fetch_instr", fullInstruction, 32'hB0);
        fetch_en = 0;

        start_load = 1;
        tick();
        start_load = 0;
        load_valid = 1;
        load_data  = 32'hC5;
        tick();
        start_load = 1;
        load_data  = 32'hC6;
        tick();
        start_load = 0;
        load_data  = 32'hC0;
        load_last  = 1;
        tick();
        load_valid = 0;
        load_last  = 0;
        chk("midload_restart_count", load_count, 1);
        chk("midload_restart_loaded", program_loaded, 1);
        fromPC   = 0;
        fetch_en = 1;
        tick();
        chk("midload_restart_instr", fullInstruction, 32'hC0);
        fetch_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
